// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Used by the hazard scoreboard and by Control.
package pipeline_pkg;

  localparam int STAGE_EX   = 0;
  localparam int STAGE_MEM  = 1;
  localparam int STAGE_WB   = 2;

  localparam int READY_ALU  = 1;
  localparam int READY_LOAD = 2;

  localparam int SB_REG_W   = 5;
  localparam int SB_STAGE_W = 2;

  // Entry layout for the default 5-bit/3-stage pipe
  typedef struct packed {
    logic                  valid;
    logic                  regWrite;
    logic [SB_REG_W-1:0]   rd;
    logic [SB_STAGE_W-1:0] readyStage;
  } sbEntry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/EX view of the hazard scoreboard.
// master = pipeline control, slave = scoreboard.
interface hazard_scoreboard_if #(
  parameter int NUM_READ_PORTS  = 2,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int PIPE_DEPTH      = 3,
  parameter int STAGE_W         = 2,
  parameter int COUNT_W         = 32
);
  localparam int RIW = NUM_READ_PORTS * REG_INDEX_WIDTH;
  localparam int FSW = NUM_READ_PORTS * STAGE_W;

  logic                       idValid;
  logic                       idRegWrite;
  logic [REG_INDEX_WIDTH-1:0] idWriteIndex;
  logic [STAGE_W-1:0]         idReadyStage;
  logic [RIW-1:0]             idReadIndex;
  logic [RIW-1:0]             exReadIndex;
  logic                       flush;
  logic                       stall;
  logic [FSW-1:0]             fwdSel;
  logic [PIPE_DEPTH-1:0]      stageValid;
  logic [COUNT_W-1:0]         stallCount;

  modport master (
    output idValid, idRegWrite, idWriteIndex,
    output idReadyStage, idReadIndex,
    output exReadIndex, flush,
    input  stall, fwdSel, stageValid, stallCount
  );

  modport slave (
    input  idValid, idRegWrite, idWriteIndex,
    input  idReadyStage, idReadIndex,
    input  exReadIndex, flush,
    output stall, fwdSel, stageValid, stallCount
  );

endinterface

// File: rtl/hazard_match_port.sv
// Youngest live match of one source register
// over a contiguous window of scoreboard stages.
module hazard_match_port
  import pipeline_pkg::*;
#(
  parameter int N       = 2,
  parameter int BASE    = 0,
  parameter int REG_W   = 5,
  parameter int STAGE_W = 2
) (
  input  logic [N-1:0]         valid,
  input  logic [N-1:0]         regWrite,
  input  logic [N*REG_W-1:0]   rd,
  input  logic [N*STAGE_W-1:0] rdy,
  input  logic [REG_W-1:0]     readIndex,
  output logic                 hit,
  output logic [STAGE_W-1:0]   sel,
  output logic [STAGE_W-1:0]   selRdy
);

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    selRdy = '0;
    for (int s = N - 1; s >= 0; s--) begin
      if (valid[s] && regWrite[s] &&
          readIndex != '0 &&
          rd[s*REG_W +: REG_W] == readIndex) begin
        hit    = 1'b1;
        sel    = STAGE_W'(BASE + s);
        selRdy = rdy[s*STAGE_W +: STAGE_W];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight instruction scoreboard: decode stall
// on unready RAW hazards, EX forwarding select.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int NUM_READ_PORTS  = 2,
  parameter int REG_INDEX_WIDTH = 5,
  parameter int PIPE_DEPTH      = 3,
  parameter int STAGE_W         = 2,
  parameter int COUNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam int NP = NUM_READ_PORTS;
  localparam int RW = REG_INDEX_WIDTH;
  localparam int PD = PIPE_DEPTH;
  localparam int SW = STAGE_W;

  logic [PD-1:0]    eValid;
  logic [PD-1:0]    eWrite;
  logic [PD*RW-1:0] eRd;
  logic [PD*SW-1:0] eRdy;

  logic [NP-1:0]    idHit;
  logic [NP-1:0]    exHit;
  logic [NP-1:0]    hazard;
  logic [NP*SW-1:0] idSel;
  logic [NP*SW-1:0] idRdy;
  logic [NP*SW-1:0] exSel;
  logic [NP*SW-1:0] exRdy;

  logic             stall;
  logic             accept;
  logic [COUNT_W-1:0] stallCount;

  for (genvar p = 0; p < NP; p++) begin : g_port
    // Last stage is excluded: the register file bypasses it
    hazard_match_port #(
      .N(PD - 1), .BASE(0),
      .REG_W(RW), .STAGE_W(SW)
    ) uId (
      .valid     (eValid[PD-2:0]),
      .regWrite  (eWrite[PD-2:0]),
      .rd        (eRd[(PD-1)*RW-1:0]),
      .rdy       (eRdy[(PD-1)*SW-1:0]),
      .readIndex (bus.idReadIndex[p*RW +: RW]),
      .hit       (idHit[p]),
      .sel       (idSel[p*SW +: SW]),
      .selRdy    (idRdy[p*SW +: SW])
    );

    hazard_match_port #(
      .N(PD - 1), .BASE(1),
      .REG_W(RW), .STAGE_W(SW)
    ) uEx (
      .valid     (eValid[PD-1:1]),
      .regWrite  (eWrite[PD-1:1]),
      .rd        (eRd[PD*RW-1:RW]),
      .rdy       (eRdy[PD*SW-1:SW]),
      .readIndex (bus.exReadIndex[p*RW +: RW]),
      .hit       (exHit[p]),
      .sel       (exSel[p*SW +: SW]),
      .selRdy    (exRdy[p*SW +: SW])
    );

    assign hazard[p] = idHit[p] &&
      (idRdy[p*SW +: SW] > idSel[p*SW +: SW] + SW'(1));
  end

  assign stall  = bus.idValid & ~bus.flush & (|hazard);
  assign accept = bus.idValid & ~bus.flush & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eValid     <= '0;
      eWrite     <= '0;
      eRd        <= '0;
      eRdy       <= '0;
      stallCount <= '0;
    end else begin
      eValid <= {eValid[PD-2:0], accept};
      eWrite <= {eWrite[PD-2:0], bus.idRegWrite};
      eRd    <= {eRd[(PD-1)*RW-1:0], bus.idWriteIndex};
      eRdy   <= {eRdy[(PD-1)*SW-1:0], bus.idReadyStage};
      if (stall && !(&stallCount))
        stallCount <= stallCount + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && bus.idValid)
      assert (bus.idReadyStage != '0 &&
              int'(bus.idReadyStage) <= PD - 1);
    for (int p = 0; p < NP; p++)
      if (rst_n && eValid[0] && exHit[p])
        assert (exRdy[p*SW +: SW] <= exSel[p*SW +: SW]);
  end

  assign bus.stall      = stall;
  assign bus.fwdSel     = exSel;
  assign bus.stageValid = eValid;
  assign bus.stallCount = stallCount;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations
// against an issue-time history model.
module tb_hazard_scoreboard;
  import pipeline_pkg::*;

  localparam int RW  = 5;
  localparam int NP0 = 2;
  localparam int PD0 = 3;
  localparam int SW0 = 2;
  localparam int CW0 = 32;
  localparam int NP1 = 3;
  localparam int PD1 = 5;
  localparam int SW1 = 3;
  localparam int CW1 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(
    .NUM_READ_PORTS(NP0), .REG_INDEX_WIDTH(RW),
    .PIPE_DEPTH(PD0), .STAGE_W(SW0), .COUNT_W(CW0)
  ) bus0 ();

  hazard_scoreboard_if #(
    .NUM_READ_PORTS(NP1), .REG_INDEX_WIDTH(RW),
    .PIPE_DEPTH(PD1), .STAGE_W(SW1), .COUNT_W(CW1)
  ) bus1 ();

  hazard_scoreboard #(
    .NUM_READ_PORTS(NP0), .REG_INDEX_WIDTH(RW),
    .PIPE_DEPTH(PD0), .STAGE_W(SW0), .COUNT_W(CW0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  hazard_scoreboard #(
    .NUM_READ_PORTS(NP1), .REG_INDEX_WIDTH(RW),
    .PIPE_DEPTH(PD1), .STAGE_W(SW1), .COUNT_W(CW1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Issued instruction, stamped with the edge that accepted it
  typedef struct {
    int cyc;
    bit wr;
    int rd;
    int rdy;
  } rec_t;

  rec_t hist[2][$];
  int   edges[2];
  longint cnt[2];
  int   np[2] = '{NP0, NP1};
  int   pd[2] = '{PD0, PD1};
  int   sw[2] = '{SW0, SW1};
  int   cw[2] = '{CW0, CW1};

  bit v[2], wr[2], fl[2];
  int rd[2], rdy[2];
  int idRd[2][3];
  int exRd[2][3];
  bit stallExp[2];

  int total = 0;
  int bad   = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Index of youngest writer of r aged lo..hi, or -1
  function automatic int youngest(int i, int r,
                                  int lo, int hi);
    int best = -1;
    int bestAge = 1 << 20;
    if (r == 0) return -1;
    for (int k = 0; k < hist[i].size(); k++) begin
      int age = edges[i] - hist[i][k].cyc;
      if (hist[i][k].wr && hist[i][k].rd == r &&
          age >= lo && age <= hi && age < bestAge) begin
        best = k;
        bestAge = age;
      end
    end
    return best;
  endfunction

  function automatic bit expStall(int i);
    if (!v[i] || fl[i]) return 1'b0;
    for (int p = 0; p < np[i]; p++) begin
      int k = youngest(i, idRd[i][p], 0, pd[i] - 2);
      if (k >= 0) begin
        int age = edges[i] - hist[i][k].cyc;
        if (hist[i][k].rdy > age + 1) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] expFwd(int i);
    logic [31:0] r = '0;
    for (int p = 0; p < np[i]; p++) begin
      int k = youngest(i, exRd[i][p], 1, pd[i] - 1);
      int s = (k < 0) ? 0 : edges[i] - hist[i][k].cyc;
      r |= 32'(s) << (p * sw[i]);
    end
    return r;
  endfunction

  function automatic logic [31:0] expValid(int i);
    logic [31:0] r = '0;
    for (int k = 0; k < hist[i].size(); k++)
      r[edges[i] - hist[i][k].cyc] = 1'b1;
    return r;
  endfunction

  function automatic longint cmax(int i);
    return (64'd1 << cw[i]) - 1;
  endfunction

  task automatic drive();
    bus0.idValid      = v[0];
    bus0.idRegWrite   = wr[0];
    bus0.idWriteIndex = RW'(rd[0]);
    bus0.idReadyStage = SW0'(rdy[0]);
    bus0.flush        = fl[0];
    for (int p = 0; p < NP0; p++) begin
      bus0.idReadIndex[p*RW +: RW] = RW'(idRd[0][p]);
      bus0.exReadIndex[p*RW +: RW] = RW'(exRd[0][p]);
    end
    bus1.idValid      = v[1];
    bus1.idRegWrite   = wr[1];
    bus1.idWriteIndex = RW'(rd[1]);
    bus1.idReadyStage = SW1'(rdy[1]);
    bus1.flush        = fl[1];
    for (int p = 0; p < NP1; p++) begin
      bus1.idReadIndex[p*RW +: RW] = RW'(idRd[1][p]);
      bus1.exReadIndex[p*RW +: RW] = RW'(exRd[1][p]);
    end
  endtask

  task automatic check(int i);
    logic [31:0] os, of, ov, oc;
    stallExp[i] = expStall(i);
    if (i == 0) begin
      os = 32'(bus0.stall);
      of = 32'(bus0.fwdSel);
      ov = 32'(bus0.stageValid);
      oc = 32'(bus0.stallCount);
    end else begin
      os = 32'(bus1.stall);
      of = 32'(bus1.fwdSel);
      ov = 32'(bus1.stageValid);
      oc = 32'(bus1.stallCount);
    end
    chk($sformatf("stall%0d", i), os, 32'(stallExp[i]));
    chk($sformatf("fwdSel%0d", i), of, expFwd(i));
    chk($sformatf("stageValid%0d", i), ov, expValid(i));
    chk($sformatf("stallCount%0d", i), oc, 32'(cnt[i]));
  endtask

  task automatic advance(int i);
    bit acc = v[i] && !fl[i] && !stallExp[i];
    edges[i]++;
    if (acc) begin
      rec_t r;
      r.cyc = edges[i];
      r.wr  = wr[i];
      r.rd  = rd[i];
      r.rdy = rdy[i];
      hist[i].push_back(r);
    end
    while (hist[i].size() > 0 &&
           edges[i] - hist[i][0].cyc >= pd[i])
      void'(hist[i].pop_front());
    if (stallExp[i] && cnt[i] < cmax(i)) cnt[i]++;
    for (int p = 0; p < 3; p++)
      exRd[i][p] = acc ? idRd[i][p] : int'($urandom_range(0, 7));
  endtask

  task automatic cycle();
    drive();
    #2;
    check(0);
    check(1);
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
  endtask

  task automatic setId(bit vv, bit ww, int d, int r,
                       int a, int b, bit f);
    for (int i = 0; i < 2; i++) begin
      v[i]  = vv;
      wr[i] = ww;
      rd[i] = d;
      rdy[i] = r;
      fl[i] = f;
      idRd[i][0] = a;
      idRd[i][1] = b;
      idRd[i][2] = 0;
    end
  endtask

  task automatic randId(int i);
    v[i]  = ($urandom_range(0, 7) != 0);
    wr[i] = ($urandom_range(0, 3) != 0);
    rd[i] = $urandom_range(0, 7);
    rdy[i] = $urandom_range(1, pd[i] - 1);
    for (int p = 0; p < 3; p++)
      idRd[i][p] = (p < np[i]) ? int'($urandom_range(0, 7)) : 0;
  endtask

  task automatic randRun(int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!stallExp[i]) randId(i);
        fl[i] = ($urandom_range(0, 9) == 0);
      end
      cycle();
    end
  endtask

  task automatic midReset();
    setId(0, 0, 0, 1, 0, 0, 0);
    drive();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      hist[i].delete();
      cnt[i] = 0;
    end
    check(0);
    check(1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0;
      cnt[i] = 0;
      stallExp[i] = 1'b0;
      for (int p = 0; p < 3; p++) exRd[i][p] = 0;
    end
    setId(0, 0, 0, 1, 0, 0, 0);
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();

    // ALU chain
    setId(1, 1, 5, READY_ALU, 0, 0, 0);   cycle();
    setId(1, 1, 8, READY_ALU, 5, 0, 0);   cycle();
    setId(1, 0, 0, READY_ALU, 0, 0, 0);   cycle();
    // load-use on port 1
    setId(1, 1, 6, READY_LOAD, 0, 0, 0);  cycle();
    setId(1, 1, 9, READY_ALU, 0, 6, 0);   cycle();
    cycle();
    setId(1, 0, 0, READY_ALU, 0, 0, 0);   cycle();
    // WAW shadow
    setId(1, 1, 7, READY_LOAD, 0, 0, 0);  cycle();
    setId(1, 1, 7, READY_ALU, 0, 0, 0);   cycle();
    setId(1, 1, 12, READY_ALU, 7, 7, 0);  cycle();
    setId(1, 0, 0, READY_ALU, 0, 0, 0);   cycle();
    // x0 writer and non-writer
    setId(1, 1, 0, READY_LOAD, 0, 0, 0);  cycle();
    setId(1, 0, 10, READY_LOAD, 0, 0, 0); cycle();
    setId(1, 1, 13, READY_ALU, 0, 10, 0); cycle();
    setId(1, 0, 0, READY_ALU, 0, 0, 0);   cycle();
    // flush over a load-use stall
    setId(1, 1, 6, READY_LOAD, 0, 0, 0);  cycle();
    setId(1, 1, 9, READY_ALU, 6, 0, 1);   cycle();
    setId(1, 1, 9, READY_ALU, 6, 0, 0);   cycle();
    // fill every stage, then reset mid-cycle
    for (int k = 0; k < PD1; k++) begin
      setId(1, 1, 11 + k, READY_ALU, 0, 0, 0);
      cycle();
    end
    midReset();
    setId(1, 1, 14, READY_ALU, 11, 15, 0); cycle();

    randRun(400);
    midReset();
    randRun(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
